// File: rtl/pipe_adder_pkg.sv
// Shared constants and the add/sub operation encoding for the pipelined adder.
package pipe_adder_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int STAGES_DEF = 4;

    // Operation select as carried on the sub input.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Carry-in of the lowest chunk: subtraction adds one to the inverted operand.
    function automatic logic op_carry_in(input op_e op);
        return (op == OP_SUB);
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle between a producer/consumer and the pipelined adder.
interface pipe_adder_if #(
    parameter int WIDTH = pipe_adder_pkg::WIDTH_DEF
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;

    // Producer/consumer side: offers operands and takes results.
    modport master (
        output flush, in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, y, cout, ovf
    );

    // Adder side.
    modport slave (
        input  flush, in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, y, cout, ovf
    );
endinterface

// File: rtl/adder_stage.sv
// One CW-bit chunk of the ripple: combinational add with carry-in, carry-out
// and the signed-overflow term of the chunk's top bit.
module adder_stage #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout,
    output logic          ovf
);
    logic [CW:0] full;
    logic        carry_into_top;

    // Widen by one bit so the chunk carry falls out of the sum; the carry into
    // the top bit is recovered from that bit's operands and result.
    always_comb begin
        full           = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
        s              = full[CW-1:0];
        cout           = full[CW];
        carry_into_top = a[CW-1] ^ b[CW-1] ^ full[CW-1];
        ovf            = carry_into_top ^ full[CW];
    end
endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: STAGES chunk adders separated by registers,
// each stage carrying a valid bit with per-stage backpressure.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic         clk,
    input  logic         resetn,
    pipe_adder_if.slave  bus
);
    localparam int CW = WIDTH / STAGES;

    if (STAGES < 1) begin : g_bad_stages
        $error("pipe_adder: STAGES must be at least 1");
    end else if ((WIDTH % STAGES) != 0) begin : g_bad_width
        $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end

    op_e              op;
    logic [WIDTH-1:0] b_eff;
    logic [STAGES-1:0] valid_vec;
    logic [STAGES-1:0] accept;
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] st_o;
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_y [STAGES];

    assign op    = op_e'(bus.sub);
    assign b_eff = (op == OP_SUB) ? ~bus.b : bus.b;

    // A stage can take new contents when it is empty or its contents move on;
    // resolved from the output end backwards so every stage sees its successor.
    always_comb begin
        accept = '0;
        accept[STAGES-1] = !valid_vec[STAGES-1] || bus.out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            accept[k] = !valid_vec[k] || accept[k+1];
        end
    end

    assign bus.in_ready = accept[0] || bus.flush;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] y_in;
        logic [CW-1:0]    sum;
        logic             carry;
        logic             ovf_c;

        logic             valid_q, valid_d;
        logic             c_q, c_d;
        logic             o_q, o_d;
        logic [WIDTH-1:0] a_q, a_d;
        logic [WIDTH-1:0] b_q, b_d;
        logic [WIDTH-1:0] y_q, y_d;

        if (gi == 0) begin : g_first
            assign v_in = bus.in_valid;
            assign c_in = op_carry_in(op);
            assign a_in = bus.a;
            assign b_in = b_eff;
            assign y_in = '0;
        end else begin : g_next
            assign v_in = valid_vec[gi-1];
            assign c_in = st_c[gi-1];
            assign a_in = st_a[gi-1];
            assign b_in = st_b[gi-1];
            assign y_in = st_y[gi-1];
        end

        adder_stage #(.CW(CW)) u_add (
            .a    (a_in[gi*CW +: CW]),
            .b    (b_in[gi*CW +: CW]),
            .cin  (c_in),
            .s    (sum),
            .cout (carry),
            .ovf  (ovf_c)
        );

        // Load the predecessor's work (or a bubble) when this stage accepts; flush empties it.
        always_comb begin
            valid_d = valid_q;
            c_d     = c_q;
            o_d     = o_q;
            a_d     = a_q;
            b_d     = b_q;
            y_d     = y_q;
            if (bus.flush) begin
                valid_d = 1'b0;
            end else if (accept[gi]) begin
                valid_d             = v_in;
                c_d                 = carry;
                o_d                 = ovf_c;
                a_d                 = a_in;
                b_d                 = b_in;
                y_d                 = y_in;
                y_d[gi*CW +: CW]    = sum;
            end
        end

        // Stage registers, cleared immediately by reset.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                valid_q <= 1'b0;
                c_q     <= 1'b0;
                o_q     <= 1'b0;
                a_q     <= '0;
                b_q     <= '0;
                y_q     <= '0;
            end else begin
                valid_q <= valid_d;
                c_q     <= c_d;
                o_q     <= o_d;
                a_q     <= a_d;
                b_q     <= b_d;
                y_q     <= y_d;
            end
        end

        assign valid_vec[gi] = valid_q;
        assign st_c[gi]      = c_q;
        assign st_o[gi]      = o_q;
        assign st_a[gi]      = a_q;
        assign st_b[gi]      = b_q;
        assign st_y[gi]      = y_q;
    end

    // Results come straight from the last stage's registers, masked while it is empty.
    assign bus.out_valid = valid_vec[STAGES-1];
    assign bus.y         = valid_vec[STAGES-1] ? st_y[STAGES-1] : '0;
    assign bus.cout      = valid_vec[STAGES-1] & st_c[STAGES-1];
    assign bus.ovf       = valid_vec[STAGES-1] & st_o[STAGES-1];

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits.
REQ-002 Parameter STAGES, default 4: pipeline depth; WIDTH SHALL be an integer multiple of STAGES, chunk CW = WIDTH/STAGES.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous clear of all in-flight operations.
REQ-006 in_valid  input  1  operation offered this cycle.
REQ-007 in_ready  output  1  pipeline accepts the offered operation this cycle.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 sub  input  1  0 selects a+b; 1 selects a-b.
REQ-010 out_valid  output  1  result present on y/cout/ovf.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 y  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-013 cout  output  1  raw carry out of the MSB.
REQ-014 ovf  output  1  signed two's-complement overflow.

Function
REQ-015 Arithmetic SHALL be y = a + (sub ? ~b : b) + sub; cout is the carry out of bit WIDTH-1; ovf = carry into bit WIDTH-1 XOR cout.
REQ-016 Stage k (0..STAGES-1) SHALL add chunk k of the operands with the carry registered by stage k-1 (stage 0 carry-in = sub), registering the chunk result, the carry, the not-yet-added upper operand chunks and the already-computed lower result chunks.
REQ-017 Each stage SHALL hold a valid bit; out_valid SHALL equal the valid bit of stage STAGES-1, and y/cout/ovf SHALL be driven from registers only.
REQ-018 A transfer occurs on in_valid && in_ready (input) and out_valid && out_ready (output).
REQ-019 Stage k SHALL advance when its successor is empty or advancing; the last stage advances when out_ready=1 or it is empty.
REQ-020 in_ready SHALL be 1 when stage 0 is empty or advancing; it SHALL be combinational from out_ready and the valid bits only, never from in_valid.
REQ-021 Latency SHALL be exactly STAGES cycles from input transfer to out_valid when out_ready stays high; throughput SHALL be one operation per cycle.
REQ-022 With out_ready low, the pipeline SHALL hold up to STAGES operations with no loss, duplication or reordering; a held output SHALL keep y/cout/ovf stable.
REQ-023 flush=1 SHALL clear every valid bit at the next edge; an input offered in the same cycle SHALL be discarded; in_ready SHALL be 1 during flush.
REQ-024 Data registers of invalid stages are don't-care and SHALL NOT affect any output while out_valid=0.

Reset
REQ-025 resetn=0 SHALL immediately clear all valid bits, out_valid=0, y=0, cout=0, ovf=0, irrespective of clk.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight operations; the first input accepted after deassertion emerges after STAGES cycles.
REQ-027 in_ready SHALL be 1 out of reset.

Structure
REQ-028 A shared package SHALL hold the default WIDTH/STAGES constants and the add/sub op encoding used by the ALU.
REQ-029 One sub-module, adder_stage, SHALL implement a CW-bit chunk add with carry-in/carry-out; pipe_adder SHALL instantiate STAGES copies plus the valid/handshake logic.
REQ-030 Elaboration SHALL fail if WIDTH mod STAGES != 0 or STAGES < 1; STAGES=1 SHALL give a single registered adder.

Verification (WIDTH=32, STAGES=4)
REQ-031 a=0x7FFFFFFF, b=1, sub=0, out_ready=1 -> out_valid exactly 4 cycles later, y=0x80000000, cout=0, ovf=1.
REQ-032 a=0xFFFFFFFF, b=1, sub=0 -> y=0x00000000, cout=1, ovf=0 (carry ripples through all four stages).
REQ-033 a=0, b=1, sub=1 -> y=0xFFFFFFFF, cout=0, ovf=0; a=0x80000000, b=1, sub=1 -> y=0x7FFFFFFF, ovf=1.
REQ-034 8 back-to-back ops (a=i, b=0x10*i), out_ready low cycles 3-6 -> in_ready falls once 4 ops are held, all 8 results appear in order, y stable while stalled.
REQ-035 flush with 3 ops in flight plus one offered -> none of the 4 appear; next op emerges 4 cycles after acceptance.
REQ-036 resetn pulsed low asynchronously between edges with the pipe full -> out_valid, y, cout, ovf go to 0 immediately; in_ready=1 after release.
